// File: rtl/fir_checkbits_reporter.sv
// fir_checkbits_reporter: reports FIR output samples on the mprj_io[31:16] checkbits with start/timer/end markers.
// Define FIR_REPORT_TIMER_EN to emit the per-frame 00A5 (T_BEGIN) and 005A (T_END) timer markers.
module fir_checkbits_reporter #(
  parameter int DATA_W = 32,
  parameter int OUT_W = 16,
  parameter int NUM_SAMPLES = 64,
  parameter int NUM_FRAMES = 3,
  parameter int HOLD_CYCLES = 4,
  parameter logic [OUT_W-1:0] START_MARK = 16'hAB40,
  parameter logic [OUT_W-1:0] END_MARK = 16'hAB51
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  input  logic              start,
  input  logic              ss_tvalid,
  input  logic [DATA_W-1:0] ss_tdata,
  input  logic              ss_tlast,
  output logic              ss_tready,
  output logic [OUT_W-1:0]  checkbits,
  output logic [OUT_W-1:0]  checkbits_oe_n,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam int SW = NUM_SAMPLES > 1 ? $clog2(NUM_SAMPLES) : 1;
  localparam int FW = NUM_FRAMES > 1 ? $clog2(NUM_FRAMES) : 1;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_T_BEGIN, ST_WAIT, ST_HOLD, ST_T_END, ST_END, ST_DONE} state_t;
  state_t state, state_d, after_start, after_frame;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] sample_cnt;
  logic [FW-1:0] frame_cnt;
  logic [OUT_W-1:0] cb_d;
  logic hold_done, last_sample, last_frame, accept, entering, start_go, frame_end;
  logic unused_hi;
  assign hold_done = hold_cnt == '0;
  assign last_sample = sample_cnt == SW'(NUM_SAMPLES - 1);
  assign last_frame = frame_cnt == FW'(NUM_FRAMES - 1);
  assign accept = state == ST_WAIT && ss_tvalid;
  assign entering = state_d != state;
  assign start_go = entering && state_d == ST_START;
  assign unused_hi = ^ss_tdata[DATA_W-1:OUT_W];
`ifdef FIR_REPORT_TIMER_EN
  assign after_start = ST_T_BEGIN;
  assign after_frame = ST_T_END;
  assign frame_end = state == ST_T_END && hold_done;
`else
  assign after_start = ST_WAIT;
  assign after_frame = last_frame ? ST_END : ST_WAIT;
  assign frame_end = state == ST_HOLD && hold_done && last_sample;
`endif
  // State, hold timer, counters, checkbits and sticky framing error
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state <= ST_IDLE;
      hold_cnt <= '0;
      sample_cnt <= '0;
      frame_cnt <= '0;
      checkbits <= '0;
      checkbits_oe_n <= '1;
      err <= 1'b0;
    end else begin
      state <= state_d;
      hold_cnt <= entering ? HW'(HOLD_CYCLES - 1) : hold_done ? hold_cnt : hold_cnt - HW'(1);
      sample_cnt <= start_go ? '0 : (state == ST_HOLD && hold_done) ? (last_sample ? '0 : sample_cnt + SW'(1)) : sample_cnt;
      frame_cnt <= start_go ? '0 : (frame_end && !last_frame) ? frame_cnt + FW'(1) : frame_cnt;
      checkbits <= cb_d;
      checkbits_oe_n <= start_go ? '0 : checkbits_oe_n;
      err <= start_go ? 1'b0 : (accept && ss_tlast != last_sample) ? 1'b1 : err;
    end
  end
  // Next state: every phase lasts until its hold timer expires, WAIT until a sample arrives
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE, ST_DONE: state_d = start ? ST_START : state;
      ST_START:         state_d = hold_done ? after_start : state;
      ST_T_BEGIN:       state_d = hold_done ? ST_WAIT : state;
      ST_WAIT:          state_d = ss_tvalid ? ST_HOLD : state;
      ST_HOLD:          state_d = hold_done ? (last_sample ? after_frame : ST_WAIT) : state;
      ST_T_END:         state_d = hold_done ? (last_frame ? ST_END : ST_T_BEGIN) : state;
      ST_END:           state_d = hold_done ? ST_DONE : state;
      default:          state_d = ST_IDLE;
    endcase
  end
  // Value loaded into checkbits on entry to a phase; WAIT and DONE keep the previous value
  always_comb begin
    cb_d = !entering ? checkbits :
           state_d == ST_START ? START_MARK :
           state_d == ST_T_BEGIN ? OUT_W'(16'h00A5) :
           state_d == ST_HOLD ? ss_tdata[OUT_W-1:0] :
           state_d == ST_T_END ? OUT_W'(16'h005A) :
           state_d == ST_END ? END_MARK : checkbits;
  end
  // Status outputs decoded from the current state
  always_comb begin
    ss_tready = state == ST_WAIT;
    busy = state != ST_IDLE && state != ST_DONE;
    done = state == ST_DONE;
  end
endmodule

// File: tb/tb_fir_checkbits_reporter.sv
// tb_fir_checkbits_reporter: randomized self-checking bench comparing the checkbits trace against a phase-list model.
module tb_fir_checkbits_reporter;
  localparam int H = 4;
  localparam int N = 64;
  localparam int F = 3;
  localparam int T = N * F;
  logic axis_clk = 0;
  logic axis_rst_n = 0;
  logic start = 0;
  logic ss_tvalid = 0;
  logic [31:0] ss_tdata = 0;
  logic ss_tlast = 0;
  logic ss_tready, busy, done, err;
  logic [15:0] checkbits, checkbits_oe_n;
  int checks = 0;
  int failures = 0;
  logic [31:0] smp [T];
  logic lst [T];
  int gap [T];
  int hold_pos [T];
  logic [15:0] exp_q [$];
  logic [15:0] obs_q [$];
  logic err_q [$];
  logic exp_err;
  int accepted;

  fir_checkbits_reporter #(.DATA_W(32), .OUT_W(16), .NUM_SAMPLES(N), .NUM_FRAMES(F), .HOLD_CYCLES(H),
    .START_MARK(16'hAB40), .END_MARK(16'hAB51)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .start(start), .ss_tvalid(ss_tvalid),
    .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready), .checkbits(checkbits),
    .checkbits_oe_n(checkbits_oe_n), .busy(busy), .done(done), .err(err));

  always #5 axis_clk = ~axis_clk;

  task automatic set_random();
    for (int i = 0; i < T; i++) begin
      smp[i] = $urandom;
      lst[i] = (i % N) == N - 1;
      gap[i] = 0;
    end
  endtask

  // Reference: the run as a list of phases, each WAIT repeating the previous value for 1+gap cycles.
  task automatic build_expected();
    logic [15:0] prev;
    exp_q.delete();
    exp_err = 0;
    repeat (H) exp_q.push_back(16'hAB40);
    prev = 16'hAB40;
    for (int f = 0; f < F; f++) begin
`ifdef FIR_REPORT_TIMER_EN
      repeat (H) exp_q.push_back(16'h00A5);
      prev = 16'h00A5;
`endif
      for (int s = 0; s < N; s++) begin
        int i;
        i = f * N + s;
        repeat (1 + gap[i]) exp_q.push_back(prev);
        hold_pos[i] = exp_q.size();
        prev = smp[i][15:0];
        repeat (H) exp_q.push_back(prev);
        if (lst[i] != (s == N - 1)) exp_err = 1;
      end
`ifdef FIR_REPORT_TIMER_EN
      repeat (H) exp_q.push_back(16'h005A);
`endif
    end
    repeat (H + 3) exp_q.push_back(16'hAB51);
  endtask

  task automatic do_reset();
    axis_rst_n = 0;
    start = 0;
    ss_tvalid = 0;
    repeat (2) @(negedge axis_clk);
    axis_rst_n = 1;
    @(negedge axis_clk);
  endtask

  // Pulses start, then acts as the sample source for exp_q.size() cycles, recording checkbits and err.
  task automatic drive_run(input int noise_c);
    int idx;
    int gl;
    bit noised;
    idx = 0;
    gl = gap[0];
    noised = 0;
    accepted = 0;
    obs_q.delete();
    err_q.delete();
    start = 1;
    ss_tvalid = 0;
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge axis_clk);
      start = 0;
      obs_q.push_back(checkbits);
      err_q.push_back(err);
      if (ss_tready) begin
        if (noise_c >= 0 && c >= noise_c && !noised) begin
          start = 1;
          noised = 1;
        end
        if (idx < T && gl > 0) begin
          ss_tvalid = 0;
          gl--;
        end else begin
          ss_tvalid = 1;
          ss_tdata = idx < T ? smp[idx] : $urandom;
          ss_tlast = idx < T ? lst[idx] : 1'b0;
          idx++;
          accepted++;
          gl = idx < T ? gap[idx] : 0;
        end
      end else begin
        ss_tvalid = 1'($urandom_range(0, 1));
        ss_tdata = $urandom;
        ss_tlast = 1'($urandom_range(0, 1));
      end
    end
    start = 0;
    ss_tvalid = 0;
  endtask

  function automatic int first_diff();
    for (int k = 0; k < exp_q.size(); k++)
      if (obs_q[k] !== exp_q[k]) return k;
    return -1;
  endfunction

  task automatic test_reset();
    int k;
    bit seen;
    axis_rst_n = 0;
    @(negedge axis_clk);
    checks++;
    if ({checkbits, checkbits_oe_n, ss_tready, busy, done, err} !== {16'h0000, 16'hFFFF, 4'b0000}) begin
      failures++;
      $display("FAIL reset_state: cb=%h oe_n=%h rdy=%b busy=%b done=%b err=%b, want cb=0000 oe_n=ffff rest 0",
               checkbits, checkbits_oe_n, ss_tready, busy, done, err);
    end
    axis_rst_n = 1;
    @(negedge axis_clk);
    smp[0] = 32'h1234_5678;
    start = 1;
    k = 0;
    seen = 0;
    while (k < 40 && !(seen && !ss_tready)) begin
      @(negedge axis_clk);
      start = 0;
      if (ss_tready) begin
        seen = 1;
        ss_tvalid = 1;
        ss_tdata = smp[0];
        ss_tlast = 0;
      end else ss_tvalid = 0;
      k++;
    end
    checks++;
    if (k >= 40 || checkbits !== 16'h5678) begin
      failures++;
      $display("FAIL pre_reset_hold: cb=%h after %0d cycles, want 5678 within 40", checkbits, k);
    end
    #1 axis_rst_n = 0;
    #1;
    checks++;
    if ({checkbits, checkbits_oe_n, busy, ss_tready, done} !== {16'h0000, 16'hFFFF, 3'b000}) begin
      failures++;
      $display("FAIL reset_mid_hold: cb=%h oe_n=%h busy=%b rdy=%b done=%b, want 0000 ffff 0 0 0",
               checkbits, checkbits_oe_n, busy, ss_tready, done);
    end
    @(negedge axis_clk);
    axis_rst_n = 1;
    start = 1;
    @(negedge axis_clk);
    start = 0;
    checks++;
    if ({checkbits, checkbits_oe_n, busy} !== {16'hAB40, 16'h0000, 1'b1}) begin
      failures++;
      $display("FAIL restart_after_reset: cb=%h oe_n=%h busy=%b, want ab40 0000 1", checkbits, checkbits_oe_n, busy);
    end
  endtask

  task automatic test_stream();
    int fd;
    for (int i = 0; i < T; i++) begin
      smp[i] = 32'(i % N);
      lst[i] = (i % N) == N - 1;
      gap[i] = 0;
    end
    build_expected();
    do_reset();
    drive_run(-1);
    fd = first_diff();
    checks++;
    if (fd >= 0) begin
      failures++;
      $display("FAIL stream_trace: cycle %0d cb=%h, want %h", fd, obs_q[fd], exp_q[fd]);
    end
    checks++;
    if (accepted !== T) begin
      failures++;
      $display("FAIL stream_count: accepted %0d, want %0d", accepted, T);
    end
    checks++;
    if ({done, busy, err, checkbits_oe_n} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      failures++;
      $display("FAIL stream_status: done=%b busy=%b err=%b oe_n=%h, want 1 0 0 0000", done, busy, err, checkbits_oe_n);
    end
  endtask

  task automatic test_gap();
    int fd;
    set_random();
    for (int i = 0; i < T; i++) gap[i] = $urandom_range(0, 2);
    gap[5] = 10;
    build_expected();
    do_reset();
    drive_run(-1);
    fd = first_diff();
    checks++;
    if (fd >= 0) begin
      failures++;
      $display("FAIL gap_trace: cycle %0d cb=%h, want %h", fd, obs_q[fd], exp_q[fd]);
    end
    checks++;
    if (obs_q[hold_pos[5] - 1] !== smp[4][15:0]) begin
      failures++;
      $display("FAIL gap_hold_prev: cb=%h at end of gap, want %h", obs_q[hold_pos[5] - 1], smp[4][15:0]);
    end
    checks++;
    if (accepted !== T || err !== exp_err) begin
      failures++;
      $display("FAIL gap_count: accepted %0d err=%b, want %0d err=%b", accepted, err, T, exp_err);
    end
  endtask

  task automatic test_truncation();
    int fd;
    set_random();
    smp[3] = 32'hFFFF_FFF6;
    smp[70] = 32'h0001_2345;
    build_expected();
    do_reset();
    drive_run(-1);
    fd = first_diff();
    checks++;
    if (fd >= 0) begin
      failures++;
      $display("FAIL trunc_trace: cycle %0d cb=%h, want %h", fd, obs_q[fd], exp_q[fd]);
    end
    checks++;
    if (obs_q[hold_pos[3]] !== 16'hFFF6) begin
      failures++;
      $display("FAIL trunc_neg: cb=%h, want fff6", obs_q[hold_pos[3]]);
    end
    checks++;
    if (obs_q[hold_pos[70] + H - 1] !== 16'h2345) begin
      failures++;
      $display("FAIL trunc_pos: cb=%h, want 2345", obs_q[hold_pos[70] + H - 1]);
    end
  endtask

  task automatic test_framing_err();
    int fd;
    int drops;
    set_random();
    lst[10] = 1;
    build_expected();
    do_reset();
    drive_run(-1);
    fd = first_diff();
    checks++;
    if (fd >= 0) begin
      failures++;
      $display("FAIL framing_trace: cycle %0d cb=%h, want %h", fd, obs_q[fd], exp_q[fd]);
    end
    checks++;
    if ({err_q[hold_pos[10] - 1], err_q[hold_pos[10]]} !== 2'b01) begin
      failures++;
      $display("FAIL framing_rise: err before/after sample 10 = %b%b, want 01", err_q[hold_pos[10] - 1], err_q[hold_pos[10]]);
    end
    drops = 0;
    for (int k = hold_pos[10]; k < err_q.size(); k++) if (err_q[k] !== 1'b1) drops++;
    checks++;
    if (drops != 0 || err !== exp_err) begin
      failures++;
      $display("FAIL framing_sticky: %0d cycles with err low, final err=%b, want 0 and %b", drops, err, exp_err);
    end
    start = 1;
    @(negedge axis_clk);
    start = 0;
    checks++;
    if ({err, checkbits} !== {1'b0, 16'hAB40}) begin
      failures++;
      $display("FAIL framing_restart: err=%b cb=%h, want 0 ab40", err, checkbits);
    end
  endtask

  task automatic test_back_to_back();
    int fd;
    set_random();
    for (int i = 0; i < T; i++) gap[i] = $urandom_range(0, 1);
    build_expected();
    do_reset();
    drive_run(200);
    fd = first_diff();
    checks++;
    if (fd >= 0) begin
      failures++;
      $display("FAIL start_ignore_trace: cycle %0d cb=%h, want %h", fd, obs_q[fd], exp_q[fd]);
    end
`ifdef FIR_REPORT_TIMER_EN
    checks++;
    if (obs_q[H] !== 16'h00A5) begin
      failures++;
      $display("FAIL timer_begin: cb=%h after start marker, want 00a5", obs_q[H]);
    end
`else
    checks++;
    if (obs_q[H + 1 + gap[0]] !== smp[0][15:0]) begin
      failures++;
      $display("FAIL no_timer_first: cb=%h after start marker, want %h", obs_q[H + 1 + gap[0]], smp[0][15:0]);
    end
`endif
    drive_run(-1);
    fd = first_diff();
    checks++;
    if (fd >= 0) begin
      failures++;
      $display("FAIL back_to_back_trace: cycle %0d cb=%h, want %h", fd, obs_q[fd], exp_q[fd]);
    end
    checks++;
    if ({done, err} !== {1'b1, exp_err}) begin
      failures++;
      $display("FAIL back_to_back_status: done=%b err=%b, want 1 %b", done, err, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_gap();
    test_truncation();
    test_framing_err();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_checkbits_reporter.md
Name: fir_checkbits_reporter

Overview:
User-project block that drives the mprj_io[31:16] "checkbits" status protocol that the management-side bench monitors. It takes FIR output samples from an AXI-Stream-style port and emits:
- a start marker,
- per-frame timer markers,
- each result (truncated to 16 bits), held for a fixed number of cycles,
- an end marker.
It sits between fir_core's output stream and the user_project_wrapper io_out/io_oeb bits 31:16.

Parameters:
DATA_W, 32, width of the input sample bus
OUT_W, 16, checkbits width; sample is truncated to its low OUT_W bits
NUM_SAMPLES, 64, samples per frame
NUM_FRAMES, 3, frames per run
HOLD_CYCLES, 4, cycles each marker/value is held on checkbits (minimum 1)
START_MARK, 16'hAB40, run-start marker
END_MARK, 16'hAB51, run-end marker

Ports:
axis_clk  in  1  clock
axis_rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run from IDLE or DONE
ss_tvalid  in  1  input sample valid
ss_tdata  in  DATA_W  input sample (signed FIR result)
ss_tlast  in  1  marks last sample of a frame
ss_tready  out  1  block accepts a sample this cycle
checkbits  out  OUT_W  value driven to mprj_io[31:16]
checkbits_oe_n  out  OUT_W  output-enable to io_oeb, active low
busy  out  1  high in every state except IDLE and DONE
done  out  1  high while in DONE
err  out  1  sticky framing error

Behaviour:
- Reset (async, any time, including mid-run): state=IDLE, checkbits=0, checkbits_oe_n=all 1s, ss_tready=0, busy=0, done=0, err=0, all counters=0.
- Each marker/value phase loads hold_cnt=HOLD_CYCLES-1, decrements each cycle, and advances when it reaches 0.
- Every emitted marker or value is held exactly HOLD_CYCLES cycles.
- FSM states: IDLE, START, T_BEGIN, WAIT, HOLD, T_END, END, DONE.
- IDLE:
  - start=1 -> START.
  - checkbits_oe_n goes all 0 from the first START cycle and stays 0 until reset.
- START: checkbits=START_MARK. Registered, so it appears the cycle after start is sampled. Then -> T_BEGIN, frame_cnt=0.
- T_BEGIN: checkbits=16'h00A5. Then -> WAIT, sample_cnt=0.
- WAIT:
  - ss_tready=1; checkbits holds its previous value.
  - On ss_tvalid&&ss_tready: latch ss_tdata[OUT_W-1:0] to checkbits on the next cycle, go to HOLD.
  - ss_tready drops the cycle after the handshake, so exactly one sample is accepted per WAIT.
- HOLD: checkbits holds the sample. When done:
  - if sample_cnt==NUM_SAMPLES-1 -> T_END;
  - else sample_cnt++ and -> WAIT.
- T_END: checkbits=16'h005A. Then:
  - if frame_cnt==NUM_FRAMES-1 -> END;
  - else frame_cnt++ and -> T_BEGIN.
- END: checkbits=END_MARK. Then -> DONE.
- DONE:
  - checkbits stays END_MARK; done=1.
  - start -> START; err cleared on restart.
- Framing check (err is sticky; framing is always governed by sample_cnt, not tlast):
  - ss_tlast=1 on an accepted sample with sample_cnt!=NUM_SAMPLES-1 -> err=1.
  - ss_tlast=0 on an accepted sample with sample_cnt==NUM_SAMPLES-1 -> err=1.
- start asserted while busy: ignored.
- ss_tvalid outside WAIT: ignored; ss_tready=0, no data lost upstream.
- Truncation: plain bit slice, no saturation. Example: -10 (32'hFFFFFFF6) -> 16'hFFF6.
- Consecutive equal samples are each held for HOLD_CYCLES; no separator is inserted.

Optional Feature:
Macro FIR_REPORT_TIMER_EN.
- Defined: T_BEGIN and T_END phases are emitted as above.
- Undefined:
  - T_BEGIN and T_END are skipped entirely.
  - START -> WAIT directly.
  - The last HOLD of a frame -> next frame's WAIT, or END after the last frame.
  - 16'h00A5 and 16'h005A never appear.
  - Run length shrinks by 2*HOLD_CYCLES*NUM_FRAMES cycles.

Test Plan:
1. Reset mid-HOLD (axis_rst_n low 1 cycle) -> same-cycle checkbits=0, oe_n=FFFF, busy=0; a new start gives AB40 on the next cycle.
2. Default params, HOLD_CYCLES=4, source always valid, data 0..63 with tlast on the 64th sample, 3 frames:
   - sequence AB40, 00A5, 64 values, 005A (x3), then AB51;
   - each value held 4 cycles; done=1; err=0.
3. Source inserts 10 idle cycles before sample 5 -> checkbits holds sample 4, ss_tready=1 throughout the gap, no extra sample accepted.
4. Sample 32'hFFFFFFF6 -> checkbits=16'hFFF6; 32'h00012345 -> 16'h2345.
5. tlast on sample 10 of frame 0 -> err=1 and stays 1; the frame still ends after 64 samples; start in DONE clears err.
6. start pulsed during WAIT -> no effect; FIR_REPORT_TIMER_EN undefined -> no 00A5/005A phases, AB40 followed directly by the first sample.
